// File: rtl/sum_4.sv
// 4-bit carry-lookahead adder. Every internal carry is a flat sum of products
// of the per-bit generate/propagate terms and c_in. The combinational result is
// also captured on clk for pipelined users, and the group generate/propagate
// terms are exported so wider lookahead adders can be built from this block.
module sum_4 (
    output logic [3:0] S,
    output logic       c_out,
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c_in,
    input  logic       clk,
    input  logic       rst_n,
    output logic       G,
    output logic       P,
    output logic [3:0] S_r,
    output logic       c_out_r
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = A & B;
    assign p = A ^ B;

    // Lookahead carries, written out flat so no carry depends on another carry.
    always_comb begin
        c[0] = c_in;
        c[1] = g[0]
             | (p[0] & c_in);
        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & c_in);
        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
    end

    assign S     = p ^ c[3:0];
    assign c_out = c[4];

    // Group terms, independent of c_in, so that c_out == G | (P & c_in).
    assign P = &p;
    assign G = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

    // Registered copy of the result; cleared immediately while reset is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S_r     <= 4'b0000;
            c_out_r <= 1'b0;
        end else begin
            S_r     <= S;
            c_out_r <= c_out;
        end
    end

endmodule

// File: tb/tb_sum_4.sv
module tb_sum_4;

    logic [3:0] S;
    logic       c_out;
    logic [3:0] A;
    logic [3:0] B;
    logic       c_in;
    logic       clk;
    logic       rst_n;
    logic       G;
    logic       P;
    logic [3:0] S_r;
    logic       c_out_r;

    sum_4 dut (
        .S       (S),
        .c_out   (c_out),
        .A       (A),
        .B       (B),
        .c_in    (c_in),
        .clk     (clk),
        .rst_n   (rst_n),
        .G       (G),
        .P       (P),
        .S_r     (S_r),
        .c_out_r (c_out_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [3:0] s;
        logic       c;
        logic       g;
        logic       p;
        logic       chk_g;
        logic       chk_p;
        logic [3:0] s_r;
        logic       c_r;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Register model state: what the DUT should have captured.
    logic [4:0] prev_sum  = 5'd0;
    logic [4:0] reg_model = 5'd0;

    // Drive one vector just after a rising edge and queue what the monitor
    // should see at the following falling edge.
    task automatic step(input string name, input logic [3:0] a, input logic [3:0] b,
                        input logic cin, input logic rst,
                        input logic [3:0] es, input logic ec,
                        input logic eg, input logic ep,
                        input logic chk_g, input logic chk_p);
        exp_t it;
        @(posedge clk);
        reg_model = rst_n ? prev_sum : 5'd0;
        #1;
        A     = a;
        B     = b;
        c_in  = cin;
        rst_n = rst;
        if (!rst) reg_model = 5'd0;
        it.name  = name;
        it.a     = a;
        it.b     = b;
        it.cin   = cin;
        it.s     = es;
        it.c     = ec;
        it.g     = eg;
        it.p     = ep;
        it.chk_g = chk_g;
        it.chk_p = chk_p;
        it.s_r   = reg_model[3:0];
        it.c_r   = reg_model[4];
        exp_q.push_back(it);
        prev_sum = {ec, es};
    endtask

    // Monitor: compare the DUT against the queued expectation each cycle.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                checks++;
                if ({c_out, S} !== {it.c, it.s}) begin
                    errors++;
                    $display("FAIL %s sum: A=%h B=%h cin=%b got c_out=%b S=%h want c_out=%b S=%h",
                             it.name, it.a, it.b, it.cin, c_out, S, it.c, it.s);
                end
                if (it.chk_g) begin
                    checks++;
                    if (G !== it.g) begin
                        errors++;
                        $display("FAIL %s G: A=%h B=%h got %b want %b", it.name, it.a, it.b, G, it.g);
                    end
                end
                if (it.chk_p) begin
                    checks++;
                    if (P !== it.p) begin
                        errors++;
                        $display("FAIL %s P: A=%h B=%h got %b want %b", it.name, it.a, it.b, P, it.p);
                    end
                end
                checks++;
                if (c_out !== (it.g | (it.p & it.cin))) begin
                    errors++;
                    $display("FAIL %s group: c_out=%b got want G|P&cin=%b", it.name, c_out,
                             it.g | (it.p & it.cin));
                end
                checks++;
                if ({c_out_r, S_r} !== {it.c_r, it.s_r}) begin
                    errors++;
                    $display("FAIL %s reg: got c_out_r=%b S_r=%h want c_out_r=%b S_r=%h",
                             it.name, c_out_r, S_r, it.c_r, it.s_r);
                end
            end
        end
    end

    initial begin
        logic [4:0] sum;
        logic [4:0] ab;
        int         wait_cycles;
        A     = 4'h0;
        B     = 4'h0;
        c_in  = 1'b0;
        rst_n = 1'b0;

        // name        A      B     cin  rst   S     c     G     P    chkG chkP
        step("zero_cin", 4'h0, 4'h0, 1'b1, 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step("f_plus_1", 4'hF, 4'h1, 1'b0, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step("max",      4'hF, 4'hF, 1'b1, 1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step("prop_cin", 4'h0, 4'hF, 1'b1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        step("alt_bits", 4'h5, 4'hA, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("alt_hold", 4'h5, 4'hA, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("mid_rst",  4'h5, 4'hA, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("rst_rel",  4'h5, 4'hA, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        step("reload",   4'h5, 4'hA, 1'b0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

        // Exhaustive sweep, expectations from plain integer addition.
        for (int i = 0; i < 512; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       ci;
            a   = i[8:5];
            b   = i[4:1];
            ci  = i[0];
            sum = {1'b0, a} + {1'b0, b} + {4'b0, ci};
            ab  = {1'b0, a} + {1'b0, b};
            step("sweep", a, b, ci, 1'b1, sum[3:0], sum[4], ab[4], ((a ^ b) == 4'hF), 1'b1, 1'b1);
        end

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        #1;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
